// File: rtl/sensor_alarm_ctrl_if.sv
// sensor_alarm_ctrl_if: sensor/ack inputs and alarm status outputs of sensor_alarm_ctrl
//   ena        clock enable, state frozen while low
//   sensor_in  per-channel sensor level, bit 0 highest priority
//   ack        single-cycle alarm acknowledge
//   alarm_out  one-hot buzzer drive
//   alarm_id   channel in alarm, or last alarmed channel
//   busy       high in ALARM or HOLDOFF
//   event_cnt  saturating count of alarms since reset
interface sensor_alarm_ctrl_if #(
    parameter int NCH = 3
);
    localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1;
    logic           ena;
    logic [NCH-1:0] sensor_in;
    logic           ack;
    logic [NCH-1:0] alarm_out;
    logic [IDW-1:0] alarm_id;
    logic           busy;
    logic [7:0]     event_cnt;
    modport master (output ena, sensor_in, ack, input alarm_out, alarm_id, busy, event_cnt);
    modport slave  (input ena, sensor_in, ack, output alarm_out, alarm_id, busy, event_cnt);
endinterface

// File: rtl/sensor_alarm_ctrl.sv
// sensor_alarm_ctrl: debounced priority sensor alarm with timed buzzer and post-alarm holdoff
//   clk, rst   rising-edge clock, synchronous active-high reset (overrides ena)
//   bus        sensor_alarm_ctrl_if.slave: ena/sensor_in/ack in, alarm_out/alarm_id/busy/event_cnt out
//   ALARM_LATCH_EN (macro): alarm ignores timer expiry and is held until ack
module sensor_alarm_ctrl #(
    parameter int NCH            = 3,
    parameter int DEBOUNCE       = 100,
    parameter int ALARM_CYCLES   = 100000000,
    parameter int HOLDOFF_CYCLES = 1000
) (
    input logic                clk,
    input logic                rst,
    sensor_alarm_ctrl_if.slave bus
);
    localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {IDLE, QUALIFY, ALARM, HOLDOFF} state_t;

    state_t         state_q;
    logic [6:0]     cnt_q;
    logic [IDW-1:0] cand_q;
    logic [IDW-1:0] id_q;
    logic [26:0]    timer_q;
    logic [NCH-1:0] alarm_q;
    logic           busy_q;
    logic [7:0]     evt_q;

    logic           hit;
    logic [IDW-1:0] ch;
    logic [6:0]     cnt_d;
    logic           alarm_done;

    // lowest-index asserted sensor wins; same channel extends the streak, a new one restarts at 1
    always_comb begin
        hit = |bus.sensor_in;
        ch  = '0;
        for (int i = NCH - 1; i >= 0; i--)
            if (bus.sensor_in[i]) ch = IDW'(i);
        cnt_d = (ch == cand_q) ? cnt_q + 7'd1 : 7'd1;
    end

`ifdef ALARM_LATCH_EN
    assign alarm_done = bus.ack;
`else
    assign alarm_done = bus.ack || (timer_q == 27'(ALARM_CYCLES));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            id_q    <= '0;
            timer_q <= '0;
            alarm_q <= '0;
            busy_q  <= 1'b0;
            evt_q   <= '0;
        end else if (bus.ena) begin
            case (state_q)
                IDLE, QUALIFY: begin
                    if (!hit) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (cnt_d == 7'(DEBOUNCE)) begin
                        state_q <= ALARM;
                        cnt_q   <= '0;
                        cand_q  <= ch;
                        id_q    <= ch;
                        alarm_q <= NCH'(1) << ch;
                        timer_q <= 27'd1;
                        busy_q  <= 1'b1;
                        evt_q   <= (evt_q == 8'hff) ? evt_q : evt_q + 8'd1;
                    end else begin
                        state_q <= QUALIFY;
                        cnt_q   <= cnt_d;
                        cand_q  <= ch;
                    end
                end
                ALARM: begin
                    if (alarm_done) begin
                        alarm_q <= '0;
                        // a zero-length holdoff drops straight back to IDLE
                        state_q <= (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
                        busy_q  <= (HOLDOFF_CYCLES != 0);
                        timer_q <= (HOLDOFF_CYCLES == 0) ? 27'd0 : 27'd1;
                    end else begin
                        timer_q <= timer_q + 27'd1;
                    end
                end
                HOLDOFF: begin
                    if (timer_q == 27'(HOLDOFF_CYCLES)) begin
                        state_q <= IDLE;
                        timer_q <= '0;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        timer_q <= timer_q + 27'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.alarm_out = alarm_q;
    assign bus.alarm_id  = id_q;
    assign bus.busy      = busy_q;
    assign bus.event_cnt = evt_q;
endmodule

// File: tb/tb_sensor_alarm_ctrl.sv
// tb_sensor_alarm_ctrl: directed and random checks of sensor_alarm_ctrl against a streak/countdown model
module tb_sensor_alarm_ctrl;
    localparam int NCH = 3;
    localparam int DEB = 4;
    localparam int AC  = 10;
    localparam int HC  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sensor_alarm_ctrl_if #(.NCH(NCH)) bus ();

    sensor_alarm_ctrl #(
        .NCH(NCH), .DEBOUNCE(DEB), .ALARM_CYCLES(AC), .HOLDOFF_CYCLES(HC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    // model: streak of identical winning channels, remaining alarm/holdoff cycles
    int alarm_left = 0;
    int hold_left = 0;
    int streak[$];
    int m_id = 0;
    int m_events = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic r, input logic e, input logic [2:0] s, input logic a);
        int ch;
        if (r) begin
            alarm_left = 0;
            hold_left  = 0;
            streak.delete();
            m_id       = 0;
            m_events   = 0;
        end else if (e) begin
            if (alarm_left > 0) begin
                if (a || alarm_left == 1) begin
                    alarm_left = 0;
                    hold_left  = HC;
                end else begin
                    alarm_left--;
                end
            end else if (hold_left > 0) begin
                hold_left--;
            end else begin
                ch = -1;
                for (int i = NCH - 1; i >= 0; i--)
                    if (s[i]) ch = i;
                if (ch < 0) begin
                    streak.delete();
                end else begin
                    if (streak.size() > 0 && streak[$] != ch) streak.delete();
                    streak.push_back(ch);
                    if (streak.size() == DEB) begin
                        alarm_left = AC;
                        m_id       = ch;
                        if (m_events < 255) m_events++;
                        streak.delete();
                    end
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [2:0] s, input logic a);
        logic [2:0] exp_out;
        rst           = r;
        bus.ena       = e;
        bus.sensor_in = s;
        bus.ack       = a;
        @(posedge clk);
        model(r, e, s, a);
        #1;
        exp_out = (alarm_left > 0) ? 3'(1 << m_id) : 3'b000;
        chk("alarm_out", 32'(bus.alarm_out), 32'(exp_out));
        chk("alarm_id", 32'(bus.alarm_id), 32'(m_id));
        chk("busy", 32'(bus.busy), 32'(alarm_left > 0 || hold_left > 0));
        chk("event_cnt", 32'(bus.event_cnt), 32'(m_events));
    endtask

    initial begin
        int hi;
        logic [2:0] s;
        bus.ena = 1'b1;
        bus.sensor_in = '0;
        bus.ack = 1'b0;
        // reset
        step(1, 1, 3'b000, 0);
        step(1, 0, 3'b111, 1);
        chk("rst_out", 32'(bus.alarm_out), 0);
        chk("rst_evt", 32'(bus.event_cnt), 0);
        // channel 1 held: alarm after 4th sample, 10 cycles, 3 holdoff
        repeat (3) step(0, 1, 3'b010, 0);
        chk("pre_alarm", 32'(bus.alarm_out), 0);
        step(0, 1, 3'b010, 0);
        chk("alarm_ch1", 32'(bus.alarm_out), 32'b010);
        chk("alarm_id1", 32'(bus.alarm_id), 1);
        repeat (9) step(0, 1, 3'b010, 0);
        chk("alarm_still", 32'(bus.alarm_out), 32'b010);
        step(0, 1, 3'b010, 0);
        chk("alarm_clr", 32'(bus.alarm_out), 0);
        chk("holdoff_busy", 32'(bus.busy), 1);
        repeat (3) step(0, 1, 3'b000, 0);
        chk("busy_low", 32'(bus.busy), 0);
        chk("evt1", 32'(bus.event_cnt), 1);
        chk("id_held", 32'(bus.alarm_id), 1);
        // priority: 110 -> channel 1
        repeat (4) step(0, 1, 3'b110, 0);
        chk("prio_id", 32'(bus.alarm_id), 1);
        repeat (13) step(0, 1, 3'b000, 0);
        // broken streaks never alarm
        repeat (3) step(0, 1, 3'b010, 0);
        step(0, 1, 3'b000, 0);
        repeat (3) step(0, 1, 3'b010, 0);
        step(0, 1, 3'b000, 0);
        chk("no_alarm", 32'(bus.busy), 0);
        // ack at timer=5
        repeat (4) step(0, 1, 3'b100, 0);
        repeat (4) step(0, 1, 3'b000, 0);
        step(0, 1, 3'b000, 1);
        chk("ack_clr", 32'(bus.alarm_out), 0);
        repeat (3) step(0, 1, 3'b000, 1);
        // ack on expiry cycle
        repeat (4) step(0, 1, 3'b001, 0);
        repeat (9) step(0, 1, 3'b000, 0);
        step(0, 1, 3'b000, 1);
        repeat (4) step(0, 1, 3'b000, 0);
        // reset mid-alarm
        repeat (4) step(0, 1, 3'b001, 0);
        repeat (3) step(0, 1, 3'b000, 0);
        step(1, 1, 3'b000, 0);
        chk("rst_mid_out", 32'(bus.alarm_out), 0);
        chk("rst_mid_busy", 32'(bus.busy), 0);
        chk("rst_mid_evt", 32'(bus.event_cnt), 0);
        // ena low 7 cycles mid-alarm stretches it to 17
        repeat (4) step(0, 1, 3'b100, 0);
        hi = 1;
        repeat (3) begin step(0, 1, 3'b000, 0); hi += (bus.alarm_out != 0) ? 1 : 0; end
        repeat (7) begin step(0, 0, 3'b000, 0); hi += (bus.alarm_out != 0) ? 1 : 0; end
        repeat (12) begin step(0, 1, 3'b000, 0); hi += (bus.alarm_out != 0) ? 1 : 0; end
        chk("alarm_len", 32'(hi), 17);
        // random
        s = 3'b000;
        repeat (1500) begin
            if ($urandom_range(0, 3) == 0) s = 3'($urandom_range(0, 7));
            step($urandom_range(0, 299) == 0, $urandom_range(0, 7) != 0, s, $urandom_range(0, 15) == 0);
        end
        // saturation of event count
        step(1, 1, 3'b000, 0);
        repeat (256 * (DEB + AC + HC) + 20) step(0, 1, 3'b001, 0);
        chk("evt_sat", 32'(bus.event_cnt), 255);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
